fetch_stage: RTL

// - IF stage of the LEGv8 pipeline: owns the PC, drives the instruction ROM address, captures the

---
 rtl/arki_fetch_pkg.sv | 21 ++
 rtl/fetch_pc_reg.sv | 38 +++
 rtl/fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/arki_fetch_pkg.sv
// rtl/arki_fetch_pkg.sv - shared types and constants for the LEGv8 IF stage
package arki_fetch_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 6;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hd503201f;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    function automatic if_id_t bubble();
        if_id_t b;
        b.pc    = '0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with next-pc select and ROM range check
module fetch_pc_reg
    import arki_fetch_pkg::*;
#(
    parameter int N = PC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] pc,
    output logic         in_range
);
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    assign pc       = pc_q;
    assign in_range = (pc_q[N-1:8] == '0);

    // An out-of-range pc parks here until a redirect pulls it back.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~N'(3);
        end else if (!stall && in_range) begin
            pc_d = pc_q + N'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 IF stage: ROM addressing, IF/ID register, fault flag, fetch counter
module fetch_stage
    import arki_fetch_pkg::*;
#(
    parameter int N     = PC_W,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [N-1:0]       redirect_pc,
    input  logic               flush,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic [N-1:0]       if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               fetch_fault,
    output logic [CNT_W-1:0]   fetch_count
);
    logic [N-1:0] pc;
    logic         in_range;

    if_id_t           if_id_q, if_id_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    fetch_pc_reg #(.N(N)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .in_range    (in_range)
    );

    assign imem_addr   = pc[IMEM_AW+1:2];
    assign if_id_pc    = N'(if_id_q.pc);
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

    always_comb begin
        if_id_d = if_id_q;
        fault_d = fault_q;
        count_d = count_q;
        if (redirect) begin
            if_id_d = bubble();
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else if (flush) begin
            if_id_d = bubble();
        end else if (!stall) begin
            if (in_range) begin
                if_id_d.pc    = PC_W'(pc);
                if_id_d.instr = imem_q;
                if_id_d.valid = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                if_id_d = bubble();
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_q <= bubble();
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end
endmodule
